// File: rtl/mem_contention_csr_responder_pkg.sv
// rtl/mem_contention_csr_responder_pkg.sv - shared CSR addresses, CTRL bit positions and CSR FSM states
// Purpose: constants and types shared by the memory-contention CSR responder files.
// Ports: none (package).
package neuraedge_csr_pkg;

  localparam logic [7:0] CSR_MEMCTL_CTRL  = 8'hD0;
  localparam logic [7:0] CSR_MEMCTL_RATE  = 8'hD4;
  localparam logic [7:0] CSR_MEMCTL_LVL   = 8'hD8;
  localparam logic [7:0] CSR_MEMCTL_BMAX  = 8'hDC;
  localparam logic [7:0] CSR_MEMCTL_GRANT = 8'hE0;
  localparam logic [7:0] CSR_MEMCTL_STALL = 8'hE4;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_LCLR_BIT = 1;
  localparam int CTRL_SCLR_BIT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1,
    DRAIN = 2'd2
  } csr_state_e;

endpackage

// File: rtl/mem_contention_csr_responder_if.sv
// rtl/mem_contention_csr_responder_if.sv - CSR request/response bus between initiator and responder
// Purpose: bundles the CSR handshake so the responder and its initiator share one port.
// Ports (signals): csr_valid/csr_write/csr_addr/csr_wdata driven by master,
//   csr_rdata/csr_ready driven by slave.
interface mem_contention_csr_responder_if;
  logic        csr_valid;
  logic        csr_write;
  logic [7:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_ready;

  modport master (output csr_valid, csr_write, csr_addr, csr_wdata,
                  input  csr_rdata, csr_ready);
  modport slave  (input  csr_valid, csr_write, csr_addr, csr_wdata,
                  output csr_rdata, csr_ready);
endinterface

// File: rtl/mem_contention_csr_responder_rr_arb.sv
// rtl/mem_contention_csr_responder_rr_arb.sv - round-robin one-hot arbiter for tile memory requests
// Purpose: picks the first requester at or after ptr when advance is set.
// Ports: req (in, NUM_TILES), advance (in), ptr (in), gnt (out, one-hot),
//   next_ptr (out, granted index + 1 mod NUM_TILES, else ptr).
module mem_contention_rr_arb #(
  parameter int NUM_TILES = 4,
  parameter int PW        = $clog2(NUM_TILES)
) (
  input  logic [NUM_TILES-1:0] req,
  input  logic                 advance,
  input  logic [PW-1:0]        ptr,
  output logic [NUM_TILES-1:0] gnt,
  output logic [PW-1:0]        next_ptr
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_TILES; i++) begin
      // Rotate the search origin so NUM_TILES need not be a power of two.
      idx = PW'((int'(ptr) + i) % NUM_TILES);
      if (advance && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        next_ptr = PW'((int'(idx) + 1) % NUM_TILES);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_contention_csr_responder.sv
// rtl/mem_contention_csr_responder.sv - CSR responder fronting a token-bucket DRAM contention regulator
// Purpose: round-robin tile grants gated by a refilled token bucket, with CSR access to
//   enable, rate, bucket size, live token level and grant/stall statistics.
// Ports: clk, rst_n (async active-low); csr (slave CSR bus); tile_req (in, NUM_TILES);
//   tile_gnt (out, one-hot); mem_ready (in).
module mem_contention_csr_responder
  import neuraedge_csr_pkg::*;
#(
  parameter int          NUM_TILES       = 4,
  parameter logic [15:0] RST_RATE_TOKENS = 16'd1,
  parameter logic [15:0] RST_RATE_PERIOD = 16'd1,
  parameter logic [15:0] RST_BUCKET_MAX  = 16'd64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  mem_contention_csr_responder_if.slave  csr,
  input  logic [NUM_TILES-1:0]           tile_req,
  output logic [NUM_TILES-1:0]           tile_gnt,
  input  logic                           mem_ready
);

  localparam int PW = $clog2(NUM_TILES);

  csr_state_e  state, state_nxt;
  logic [7:0]  s_addr;
  logic        s_write;
  logic [31:0] s_wdata;
  logic [31:0] rdata_q, rd_mux;

  logic        ctrl_en;
  logic [15:0] rate_tokens, rate_period, bucket_max, level, pcnt;
  logic [31:0] gcnt, scnt;
  logic [PW-1:0] rr_ptr, next_ptr;

  logic        commit, wr_ctrl, wr_rate, wr_bmax;
  logic        any_req, advance, consume, stall, wrap;
  logic [15:0] pmax, refill, lvl_nxt;
  logic signed [17:0] lvl_sum;

  // CSR FSM: DRAIN waits for the initiator to drop the request it was just answered for.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (csr.csr_valid) state_nxt = RESP;
      RESP:    state_nxt = DRAIN;
      DRAIN:   if (!csr.csr_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (csr.csr_addr)
      CSR_MEMCTL_CTRL:  rd_mux = {31'd0, ctrl_en};
      CSR_MEMCTL_RATE:  rd_mux = {rate_period, rate_tokens};
      CSR_MEMCTL_LVL:   rd_mux = {16'd0, level};
      CSR_MEMCTL_BMAX:  rd_mux = {16'd0, bucket_max};
      CSR_MEMCTL_GRANT: rd_mux = gcnt;
      CSR_MEMCTL_STALL: rd_mux = scnt;
      default:          rd_mux = '0;
    endcase
  end

  assign csr.csr_ready = (state == RESP);
  assign csr.csr_rdata = rdata_q;
  assign commit  = (state == RESP) && s_write;
  assign wr_ctrl = commit && (s_addr == CSR_MEMCTL_CTRL);
  assign wr_rate = commit && (s_addr == CSR_MEMCTL_RATE);
  assign wr_bmax = commit && (s_addr == CSR_MEMCTL_BMAX);

  // Refill fires on the last count of the period; a zero period behaves as one.
  assign pmax   = (rate_period == 16'd0) ? 16'd1 : rate_period;
  assign wrap   = (pcnt >= pmax - 16'd1);
  assign refill = wrap ? rate_tokens : 16'd0;

  // Reset is folded in so the grant drops the instant rst_n falls.
  assign any_req = |tile_req;
  assign advance = rst_n && any_req && mem_ready && (!ctrl_en || level != 16'd0);
  assign consume = ctrl_en && advance;
  assign stall   = any_req && mem_ready && ctrl_en && (level == 16'd0);

  always_comb begin
    lvl_sum = $signed({2'b00, level}) + $signed({2'b00, refill}) - $signed({17'd0, consume});
    if (lvl_sum[17])                              lvl_nxt = '0;
    else if (lvl_sum > $signed({2'b00, bucket_max})) lvl_nxt = bucket_max;
    else                                          lvl_nxt = lvl_sum[15:0];
  end

  mem_contention_rr_arb #(.NUM_TILES(NUM_TILES), .PW(PW)) u_arb (
    .req      (tile_req),
    .advance  (advance),
    .ptr      (rr_ptr),
    .gnt      (tile_gnt),
    .next_ptr (next_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      s_addr  <= '0;
      s_write <= 1'b0;
      s_wdata <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && csr.csr_valid) begin
        s_addr  <= csr.csr_addr;
        s_write <= csr.csr_write;
        s_wdata <= csr.csr_wdata;
        rdata_q <= csr.csr_write ? 32'd0 : rd_mux;
      end else if (state == RESP) begin
        rdata_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en     <= 1'b0;
      rate_tokens <= RST_RATE_TOKENS;
      rate_period <= RST_RATE_PERIOD;
      bucket_max  <= RST_BUCKET_MAX;
    end else begin
      if (wr_ctrl) ctrl_en <= s_wdata[CTRL_EN_BIT];
      if (wr_rate) {rate_period, rate_tokens} <= s_wdata;
      if (wr_bmax) bucket_max <= s_wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level  <= RST_BUCKET_MAX;
      pcnt   <= '0;
      rr_ptr <= '0;
      gcnt   <= '0;
      scnt   <= '0;
    end else begin
      pcnt   <= wrap ? 16'd0 : pcnt + 16'd1;
      rr_ptr <= next_ptr;
      level  <= (wr_ctrl && s_wdata[CTRL_LCLR_BIT]) ? 16'd0 : lvl_nxt;
      if (wr_ctrl && s_wdata[CTRL_SCLR_BIT]) begin
        gcnt <= '0;
        scnt <= '0;
      end else begin
        if (advance && gcnt != 32'hFFFF_FFFF) gcnt <= gcnt + 32'd1;
        if (stall   && scnt != 32'hFFFF_FFFF) scnt <= scnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_contention_csr_responder.sv
// tb/tb_mem_contention_csr_responder.sv - self-checking bench for mem_contention_csr_responder
module tb_mem_contention_csr_responder;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] tile_req;
  logic [N-1:0] tile_gnt;
  logic         mem_ready;

  mem_contention_csr_responder_if bus ();

  mem_contention_csr_responder #(.NUM_TILES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .csr       (bus.slave),
    .tile_req  (tile_req),
    .tile_gnt  (tile_gnt),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: register values as seen by the bus.
  int          m_en, m_tokens, m_period, m_bmax, m_level, m_pcnt, m_ptr;
  logic [31:0] m_gcnt, m_scnt;
  bit          pend_wr;
  logic [7:0]  pend_a;
  logic [31:0] pend_d;
  bit          exp_ready, chk_rdata;
  logic [31:0] exp_rdata, last_rdata, rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_tokens = 1; m_period = 1; m_bmax = 64; m_level = 64;
    m_pcnt = 0; m_ptr = 0; m_gcnt = 0; m_scnt = 0; pend_wr = 0;
  endtask

  function automatic int model_pick();
    if (!rst_n || tile_req == '0 || !mem_ready) return -1;
    if (m_en != 0 && m_level == 0) return -1;
    for (int k = 0; k < N; k++)
      if (tile_req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      8'hD0: return 32'(m_en);
      8'hD4: return {16'(m_period), 16'(m_tokens)};
      8'hD8: return 32'(m_level);
      8'hDC: return 32'(m_bmax);
      8'hE0: return m_gcnt;
      8'hE4: return m_scnt;
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model across one rising edge, using the values held during the cycle.
  task automatic model_edge();
    int pm, ref_t, g, lvl;
    bit stall;
    pm    = (m_period == 0) ? 1 : m_period;
    ref_t = 0;
    if (m_pcnt >= pm - 1) begin ref_t = m_tokens; m_pcnt = 0; end
    else m_pcnt++;
    g     = model_pick();
    stall = (tile_req != '0) && mem_ready && m_en != 0 && m_level == 0;
    lvl   = m_level + ref_t - ((m_en != 0 && g >= 0) ? 1 : 0);
    if (lvl > m_bmax) lvl = m_bmax;
    if (lvl < 0) lvl = 0;
    if (g >= 0) begin
      m_ptr = (g + 1) % N;
      if (m_gcnt != 32'hFFFF_FFFF) m_gcnt++;
    end
    if (stall && m_scnt != 32'hFFFF_FFFF) m_scnt++;
    if (pend_wr) begin
      case (pend_a)
        8'hD0: begin
          m_en = int'(pend_d[0]);
          if (pend_d[1]) lvl = 0;
          if (pend_d[2]) begin m_gcnt = 0; m_scnt = 0; end
        end
        8'hD4: begin m_tokens = int'(pend_d[15:0]); m_period = int'(pend_d[31:16]); end
        8'hDC: m_bmax = int'(pend_d[15:0]);
        default: ;
      endcase
    end
    m_level = lvl;
    pend_wr = 0;
  endtask

  // Entered at a falling edge with inputs set; checks mid-cycle, then crosses one rising edge.
  task automatic tick();
    int p;
    #1;
    p = model_pick();
    check("tile_gnt", 32'(tile_gnt), (p >= 0) ? (32'd1 << p) : 32'd0);
    check("csr_ready", 32'(bus.csr_ready), 32'(exp_ready));
    if (exp_ready && chk_rdata) check("csr_rdata", bus.csr_rdata, exp_rdata);
    if (exp_ready) last_rdata = bus.csr_rdata;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic csr(input bit wr, input logic [7:0] a, input logic [31:0] d,
                     input int hold_extra, output logic [31:0] rdv);
    bus.csr_valid = 1'b1; bus.csr_write = wr; bus.csr_addr = a; bus.csr_wdata = d;
    exp_rdata = wr ? 32'd0 : model_read(a);
    exp_ready = 0;
    tick();
    exp_ready = 1; chk_rdata = !wr;
    pend_wr = wr; pend_a = a; pend_d = d;
    tick();
    exp_ready = 0; chk_rdata = 0;
    repeat (hold_extra) tick();
    bus.csr_valid = 1'b0;
    tick();
    rdv = last_rdata;
  endtask

  initial begin
    rst_n = 1'b0; tile_req = '0; mem_ready = 1'b0;
    bus.csr_valid = 1'b0; bus.csr_write = 1'b0; bus.csr_addr = '0; bus.csr_wdata = '0;
    exp_ready = 0; chk_rdata = 0; last_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    tile_req = 4'b0001; mem_ready = 1'b1;
    #1;
    check("reset_ready", 32'(bus.csr_ready), 32'd0);
    check("reset_rdata", bus.csr_rdata, 32'd0);
    check("reset_gnt", 32'(tile_gnt), 32'd0);
    @(negedge clk);
    tile_req = '0; mem_ready = 1'b0;
    rst_n = 1'b1;

    // Enable write, held one extra cycle to show no second accept; readback.
    csr(1, 8'hD0, 32'h1, 1, rd);
    csr(0, 8'hD0, 32'h0, 0, rd);
    check("t1_ctrl", rd, 32'h1);

    // Token bucket fills to BUCKET_MAX while disabled.
    csr(1, 8'hD0, 32'h0, 0, rd);
    csr(1, 8'hD4, 32'h0004_0002, 0, rd);
    csr(1, 8'hDC, 32'd8, 0, rd);
    csr(1, 8'hD0, 32'h2, 0, rd);
    repeat (40) tick();
    csr(0, 8'hD8, 32'h0, 0, rd);
    check("t2_level_sat", rd, 32'd8);

    // Regulated single requester: burst from the bucket, then rate-limited.
    csr(1, 8'hD0, 32'h1, 0, rd);
    tile_req = 4'b0001; mem_ready = 1'b1;
    repeat (30) tick();
    csr(0, 8'hE4, 32'h0, 0, rd);
    check("t3_stall_nonzero", 32'(rd != 0), 32'd1);
    csr(0, 8'hD8, 32'h0, 0, rd);
    check("t3_level_le_max", 32'(rd <= 8), 32'd1);

    // Unregulated three-way round robin, then memory back-pressure.
    tile_req = '0;
    csr(1, 8'hD0, 32'h4, 0, rd);
    tile_req = 4'b0111;
    repeat (12) tick();
    mem_ready = 1'b0;
    repeat (4) tick();
    csr(0, 8'hE0, 32'h0, 0, rd);
    tile_req = '0; mem_ready = 1'b1;

    // Shrinking BUCKET_MAX clamps the level; unmapped address access.
    csr(1, 8'hDC, 32'd3, 0, rd);
    csr(0, 8'hD8, 32'h0, 0, rd);
    check("t5_level_clamped", rd, 32'd3);
    csr(0, 8'h10, 32'h0, 0, rd);
    check("t5_unmapped_read", rd, 32'd0);
    csr(1, 8'h10, 32'hFFFF_FFFF, 0, rd);
    csr(0, 8'hD0, 32'h0, 0, rd);
    csr(0, 8'hD4, 32'h0, 0, rd);
    csr(0, 8'hDC, 32'h0, 0, rd);

    // Randomized traffic with interleaved configuration changes.
    for (int it = 0; it < 250; it++) begin
      tile_req  = N'($urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 4))
          0: csr(1, 8'hD0, 32'($urandom_range(0, 7)), 0, rd);
          1: csr(1, 8'hD4, {16'($urandom_range(0, 5)), 16'($urandom_range(0, 3))}, 0, rd);
          2: csr(1, 8'hDC, 32'($urandom_range(0, 12)), 0, rd);
          default: csr(0, 8'hD0 + 8'(4 * $urandom_range(0, 5)), 32'h0, $urandom_range(0, 1), rd);
        endcase
      end else begin
        tick();
      end
    end

    // Reset during RESP aborts the write and drops outputs at once.
    tile_req = 4'b0011; mem_ready = 1'b1;
    bus.csr_valid = 1'b1; bus.csr_write = 1'b1; bus.csr_addr = 8'hD0; bus.csr_wdata = 32'h1;
    exp_rdata = 32'd0;
    tick();
    #1;
    check("t6_ready_in_resp", 32'(bus.csr_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_ready_async", 32'(bus.csr_ready), 32'd0);
    check("t6_gnt_async", 32'(tile_gnt), 32'd0);
    bus.csr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tile_req = '0;
    csr(0, 8'hD0, 32'h0, 0, rd);
    check("t6_ctrl_reset", rd, 32'd0);
    csr(0, 8'hD8, 32'h0, 0, rd);
    check("t6_level_reset", rd, 32'd64);
    csr(0, 8'hE0, 32'h0, 0, rd);
    check("t6_gcnt_reset", rd, 32'd0);
    csr(0, 8'hE4, 32'h0, 0, rd);
    check("t6_scnt_reset", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
